mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results to writeback, or runs one aligned load/store
// on a single-outstanding request/ack bus with a timeout abort.
module mem_stage #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [4:0]        addr_reg_wr_i,
  input  logic              reg_wr_en_i,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [DATA_W-1:0] addr_mem_rd_i,
  input  logic [DATA_W-1:0] addr_mem_wr_i,
  input  logic [DATA_W-1:0] data_mem_wr_i,
  input  logic [2:0]        load_code_i,
  input  logic [1:0]        store_code_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [7:0]        bus_wstrb_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              hold_req_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_off;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_store;
  logic [4:0]        r_rd;
  logic              r_reg_wr;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [DATA_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [7:0]        r_bus_wstrb;
  logic              r_wb_en;
  logic [4:0]        r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_misalign;
  logic              r_bus_err;

  logic              w_st_req;
  logic              w_ld_req;
  logic              w_mem_req;
  logic [DATA_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic              w_sign;
  logic              w_misalign;
  logic [7:0]        w_mask;
  logic              w_accept;
  logic              w_ack;
  logic              w_timeout;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_load;

  // Store wins over load; load code 0 means "no load" even if mem_rd_en_i is set.
  assign w_st_req  = valid_i & mem_wr_en_i;
  assign w_ld_req  = valid_i & mem_rd_en_i & ~mem_wr_en_i & (load_code_i != 3'd0);
  assign w_mem_req = w_st_req | w_ld_req;
  assign w_addr    = w_st_req ? addr_mem_wr_i : addr_mem_rd_i;

  // Access size as log2(bytes), signedness, alignment and lane mask of the incoming request.
  always_comb begin
    w_size = 2'd0;
    w_sign = 1'b0;
    if (w_st_req) begin
      w_size = store_code_i;
    end else begin
      case (load_code_i)
        3'd1:    begin w_size = 2'd0; w_sign = 1'b1; end
        3'd2:    begin w_size = 2'd1; w_sign = 1'b1; end
        3'd3:    begin w_size = 2'd2; w_sign = 1'b1; end
        3'd4:    w_size = 2'd3;
        3'd6:    w_size = 2'd1;
        3'd7:    w_size = 2'd2;
        default: w_size = 2'd0;
      endcase
    end
    case (w_size)
      2'd0:    begin w_misalign = 1'b0;           w_mask = 8'h01; end
      2'd1:    begin w_misalign = w_addr[0];      w_mask = 8'h03; end
      2'd2:    begin w_misalign = |w_addr[1:0];   w_mask = 8'h0F; end
      default: begin w_misalign = |w_addr[2:0];   w_mask = 8'hFF; end
    endcase
  end

  assign w_accept  = (r_state == IDLE) & w_mem_req & ~w_misalign;
  assign w_ack     = (r_state == BUSY) & bus_ack_i;
  assign w_timeout = (r_state == BUSY) & ~bus_ack_i & (r_cnt == LAST_CNT);

  // Stall is combinational so upstream freezes in the very cycle a request is accepted.
  assign hold_req_o = w_accept | ((r_state == BUSY) & ~bus_ack_i & ~w_timeout);

  // Move the addressed lanes down to bit 0 and extend to full width.
  always_comb begin
    w_shift = bus_rdata_i >> {r_off, 3'b000};
    case (r_size)
      2'd0:    w_load = {{(DATA_W-8){r_sign & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = {{(DATA_W-16){r_sign & w_shift[15]}}, w_shift[15:0]};
      2'd2:    w_load = {{(DATA_W-32){r_sign & w_shift[31]}}, w_shift[31:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_sign      <= 1'b0;
      r_store     <= 1'b0;
      r_rd        <= '0;
      r_reg_wr    <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_wb_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem_req) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_state     <= BUSY;
              r_cnt       <= '0;
              r_off       <= w_addr[2:0];
              r_size      <= w_size;
              r_sign      <= w_sign;
              r_store     <= w_st_req;
              r_rd        <= addr_reg_wr_i;
              r_reg_wr    <= reg_wr_en_i;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_st_req;
              r_bus_addr  <= {w_addr[DATA_W-1:3], 3'b000};
              r_bus_wdata <= w_st_req ? (data_mem_wr_i << {w_addr[2:0], 3'b000}) : '0;
              r_bus_wstrb <= w_mask << w_addr[2:0];
            end
          end else if (valid_i) begin
            r_wb_en   <= reg_wr_en_i;
            r_wb_addr <= addr_reg_wr_i;
            r_wb_data <= alu_result_i;
          end
        end
        BUSY: begin
          if (w_ack || w_timeout) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            if (w_ack && !r_store) begin
              r_wb_en   <= r_reg_wr;
              r_wb_addr <= r_rd;
              r_wb_data <= w_load;
            end
            r_bus_err <= w_timeout;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_wstrb_o = r_bus_wstrb;
  assign wb_en_o     = r_wb_en;
  assign wb_addr_o   = r_wb_addr;
  assign wb_data_o   = r_wb_data;
  assign misalign_o  = r_misalign;
  assign bus_err_o   = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model checked every cycle, plus hand-computed
// literal expectations for the headline scenarios.
module tb_mem_stage;

  localparam int unsigned DW = 64;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [DW-1:0] alu_result_i;
  logic [4:0]    addr_reg_wr_i;
  logic          reg_wr_en_i;
  logic          mem_rd_en_i;
  logic          mem_wr_en_i;
  logic [DW-1:0] addr_mem_rd_i;
  logic [DW-1:0] addr_mem_wr_i;
  logic [DW-1:0] data_mem_wr_i;
  logic [2:0]    load_code_i;
  logic [1:0]    store_code_i;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [DW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [7:0]    bus_wstrb_o;
  logic          bus_ack_i;
  logic [DW-1:0] bus_rdata_i;
  logic          hold_req_o;
  logic          wb_en_o;
  logic [4:0]    wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic          misalign_o;
  logic          bus_err_o;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .addr_reg_wr_i(addr_reg_wr_i), .reg_wr_en_i(reg_wr_en_i),
    .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .addr_mem_rd_i(addr_mem_rd_i), .addr_mem_wr_i(addr_mem_wr_i),
    .data_mem_wr_i(data_mem_wr_i), .load_code_i(load_code_i), .store_code_i(store_code_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .hold_req_o(hold_req_o), .wb_en_o(wb_en_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Decode the request currently presented by the bench.
  function automatic void dec(output bit req, output bit st, output int nb, output logic [63:0] a);
    bit ld;
    st  = valid_i && mem_wr_en_i;
    ld  = valid_i && mem_rd_en_i && !mem_wr_en_i && (load_code_i != 3'd0);
    req = st || ld;
    a   = st ? addr_mem_wr_i : addr_mem_rd_i;
    if (st) nb = 1 << store_code_i;
    else begin
      case (load_code_i)
        3'd2, 3'd6: nb = 2;
        3'd3, 3'd7: nb = 4;
        3'd4:       nb = 8;
        default:    nb = 1;
      endcase
    end
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] rd, input int off, input int nb, input bit sgn);
    logic [63:0] sh;
    logic [63:0] msk;
    sh = rd >> (8 * off);
    if (nb == 8) return sh;
    msk = (64'd1 << (8 * nb)) - 64'd1;
    sh  = sh & msk;
    if (sgn && sh[8*nb-1]) sh = sh | ~msk;
    return sh;
  endfunction

  // Transaction-level reference model: expected registered outputs after each edge.
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  int          m_off, m_nb;
  bit          m_st, m_sgn, m_rwe;
  logic [4:0]  m_rd;
  bit          e_wb_en = 1'b0, e_mis = 1'b0, e_err = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [4:0]  e_wb_addr = '0;
  logic [63:0] e_wb_data = '0, e_baddr = '0, e_wdata = '0;
  logic [7:0]  e_wstrb = '0;

  task automatic clear_bus_exp();
    e_req = 1'b0; e_we = 1'b0; e_baddr = '0; e_wdata = '0; e_wstrb = '0;
  endtask

  always @(posedge clk) begin : model
    bit d_req, d_st;
    int d_nb;
    logic [63:0] d_a;
    if (rst) begin
      m_busy = 1'b0; m_wait = 0;
      e_wb_en = 1'b0; e_wb_addr = '0; e_wb_data = '0; e_mis = 1'b0; e_err = 1'b0;
      clear_bus_exp();
    end else begin
      e_wb_en = 1'b0; e_mis = 1'b0; e_err = 1'b0;
      if (!m_busy) begin
        dec(d_req, d_st, d_nb, d_a);
        if (d_req) begin
          if (d_a % 64'(d_nb) != 64'd0) e_mis = 1'b1;
          else begin
            m_busy = 1'b1; m_wait = 0;
            m_off = int'(d_a % 64'd8); m_nb = d_nb; m_st = d_st;
            m_sgn = (load_code_i == 3'd1) || (load_code_i == 3'd2) || (load_code_i == 3'd3);
            m_rd = addr_reg_wr_i; m_rwe = reg_wr_en_i;
            e_req = 1'b1; e_we = d_st;
            e_baddr = d_a - (d_a % 64'd8);
            e_wstrb = 8'(((1 << d_nb) - 1) << m_off);
            e_wdata = d_st ? (data_mem_wr_i << (8 * m_off)) : 64'd0;
          end
        end else if (valid_i) begin
          e_wb_en = reg_wr_en_i; e_wb_addr = addr_reg_wr_i; e_wb_data = alu_result_i;
        end
      end else if (bus_ack_i) begin
        m_busy = 1'b0;
        clear_bus_exp();
        if (!m_st) begin
          e_wb_en = m_rwe; e_wb_addr = m_rd;
          e_wb_data = extend(bus_rdata_i, m_off, m_nb, m_sgn);
        end
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_busy = 1'b0; e_err = 1'b1;
          clear_bus_exp();
        end
      end
    end
  end

  // Per-cycle compare plus event counters used by the literal checks.
  bit          chk_on = 1'b0;
  int          cnt_req, cnt_hold, cnt_err, cnt_mis, cnt_wb;
  bit          s_got, s_we;
  logic [63:0] s_addr, s_wdata, last_wb;
  logic [7:0]  s_strb;

  always @(negedge clk) begin : compare
    bit c_req, c_st, eh;
    int c_nb;
    logic [63:0] c_a;
    if (chk_on) begin
      if (m_busy) eh = !bus_ack_i && (m_wait + 1 != TO);
      else begin
        dec(c_req, c_st, c_nb, c_a);
        eh = c_req && (c_a % 64'(c_nb) == 64'd0);
      end
      chk("hold_req", hold_req_o, eh);
      chk("wb_en", wb_en_o, e_wb_en);
      if (e_wb_en) begin
        chk("wb_addr", wb_addr_o, e_wb_addr);
        chk("wb_data", wb_data_o, e_wb_data);
      end
      chk("misalign", misalign_o, e_mis);
      chk("bus_err", bus_err_o, e_err);
      chk("bus_req", bus_req_o, e_req);
      chk("bus_we", bus_we_o, e_we);
      chk("bus_addr", bus_addr_o, e_baddr);
      chk("bus_wstrb", bus_wstrb_o, e_wstrb);
      chk("bus_wdata", bus_wdata_o, e_wdata);
    end
    if (bus_req_o === 1'b1) begin
      cnt_req++;
      if (!s_got) begin
        s_got = 1'b1; s_we = bus_we_o; s_addr = bus_addr_o; s_wdata = bus_wdata_o; s_strb = bus_wstrb_o;
      end
    end
    if (hold_req_o === 1'b1) cnt_hold++;
    if (bus_err_o === 1'b1)  cnt_err++;
    if (misalign_o === 1'b1) cnt_mis++;
    if (wb_en_o === 1'b1) begin cnt_wb++; last_wb = wb_data_o; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; reg_wr_en_i = 1'b0; mem_rd_en_i = 1'b0; mem_wr_en_i = 1'b0;
    load_code_i = 3'd0; store_code_i = 2'd0; bus_ack_i = 1'b0;
  endtask

  task automatic clr_mon();
    cnt_req = 0; cnt_hold = 0; cnt_err = 0; cnt_mis = 0; cnt_wb = 0;
    s_got = 1'b0; last_wb = '0;
  endtask

  // One memory instruction; ack arrives after dly busy cycles, or never when ack=0.
  task automatic mem_op(input bit st, input bit ld, input logic [2:0] lc, input logic [1:0] sc,
                        input logic [63:0] a, input logic [63:0] d, input int dly,
                        input bit ack, input logic [63:0] rdata);
    clr_mon();
    valid_i = 1'b1; reg_wr_en_i = 1'b1; addr_reg_wr_i = 5'd9; alu_result_i = 64'hDEAD;
    mem_wr_en_i = st; mem_rd_en_i = ld; load_code_i = lc; store_code_i = sc;
    addr_mem_rd_i = a; addr_mem_wr_i = a; data_mem_wr_i = d;
    step();
    idle_in();
    if (ack) begin
      repeat (dly) step();
      bus_ack_i = 1'b1; bus_rdata_i = rdata;
      step();
      bus_ack_i = 1'b0;
    end else begin
      repeat (TO + 2) step();
    end
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst = 1'b1; alu_result_i = '0; addr_reg_wr_i = '0; addr_mem_rd_i = '0;
    addr_mem_wr_i = '0; data_mem_wr_i = '0; bus_rdata_i = '0;
    clr_mon();
    step();
    chk_on = 1'b1;
    step();
    chk("rst_wb_en", wb_en_o, 0);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    rst = 1'b0;

    // ALU passthrough, with a stray ack in IDLE that must be ignored
    valid_i = 1'b1; reg_wr_en_i = 1'b1; addr_reg_wr_i = 5'd5; alu_result_i = 64'h1234;
    bus_ack_i = 1'b1;
    step();
    idle_in();
    chk("alu_wb_en", wb_en_o, 1);
    chk("alu_wb_addr", wb_addr_o, 5);
    chk("alu_wb_data", wb_data_o, 64'h1234);
    chk("alu_bus_req", bus_req_o, 0);
    step();
    chk("novalid_wb_en", wb_en_o, 0);
    valid_i = 1'b1; reg_wr_en_i = 1'b0; alu_result_i = 64'h77;
    step();
    idle_in();
    chk("nowr_wb_en", wb_en_o, 0);

    mem_op(0, 1, 3'd1, 2'd0, 64'h1003, 0, 3, 1, 64'h00000000_80000000);
    chk("lb_data", last_wb, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_hold_cycles", cnt_hold, 4);
    chk("lb_req_cycles", cnt_req, 4);

    mem_op(1, 0, 3'd0, 2'd1, 64'h2006, 64'hBEEF, 1, 1, 0);
    chk("sh_we", s_we, 1);
    chk("sh_addr", s_addr, 64'h2000);
    chk("sh_wstrb", s_strb, 8'hC0);
    chk("sh_wdata", s_wdata, 64'hBEEF0000_00000000);
    chk("sh_wb_cnt", cnt_wb, 0);

    mem_op(0, 1, 3'd3, 2'd0, 64'h3002, 0, 0, 1, 0);
    chk("lw_mis_cnt", cnt_mis, 1);
    chk("lw_mis_req", cnt_req, 0);
    chk("lw_mis_hold", cnt_hold, 0);
    chk("lw_mis_wb", cnt_wb, 0);

    mem_op(0, 1, 3'd4, 2'd0, 64'h4000, 0, 0, 0, 0);
    chk("ld_to_req_cycles", cnt_req, 16);
    chk("ld_to_err_pulses", cnt_err, 1);
    chk("ld_to_wb", cnt_wb, 0);

    mem_op(0, 1, 3'd2, 2'd0, 64'h4002, 0, 0, 1, 64'h00000000_80010000);
    chk("lh_data", last_wb, 64'hFFFFFFFF_FFFF8001);
    mem_op(0, 1, 3'd6, 2'd0, 64'h4002, 0, 2, 1, 64'h00000000_80010000);
    chk("lhu_data", last_wb, 64'h8001);
    mem_op(0, 1, 3'd3, 2'd0, 64'h4004, 0, 1, 1, 64'h89ABCDEF_00000000);
    chk("lw_data", last_wb, 64'hFFFFFFFF_89ABCDEF);
    mem_op(0, 1, 3'd7, 2'd0, 64'h4004, 0, 1, 1, 64'h89ABCDEF_00000000);
    chk("lwu_data", last_wb, 64'h89ABCDEF);
    mem_op(0, 1, 3'd5, 2'd0, 64'h1003, 0, 0, 1, 64'h00000000_80000000);
    chk("lbu_data", last_wb, 64'h80);
    mem_op(0, 1, 3'd4, 2'd0, 64'h4008, 0, 2, 1, 64'h01234567_89ABCDEF);
    chk("ld_data", last_wb, 64'h01234567_89ABCDEF);

    mem_op(1, 0, 3'd0, 2'd0, 64'h5007, 64'hA5, 0, 1, 0);
    chk("sb_wstrb", s_strb, 8'h80);
    chk("sb_wdata", s_wdata, 64'hA5000000_00000000);
    mem_op(1, 0, 3'd0, 2'd2, 64'h5004, 64'h11223344, 1, 1, 0);
    chk("sw_wstrb", s_strb, 8'hF0);
    chk("sw_wdata", s_wdata, 64'h11223344_00000000);
    mem_op(1, 1, 3'd3, 2'd3, 64'h6008, 64'hCAFEF00D_12345678, 0, 1, 64'hFFFF);
    chk("both_we", s_we, 1);
    chk("both_wstrb", s_strb, 8'hFF);
    chk("both_wb", cnt_wb, 0);
    mem_op(1, 0, 3'd0, 2'd1, 64'h2001, 64'h1, 0, 1, 0);
    chk("sh_mis_cnt", cnt_mis, 1);
    chk("sh_mis_req", cnt_req, 0);

    // Ack on the last allowed cycle wins over the timeout
    mem_op(0, 1, 3'd4, 2'd0, 64'h4010, 0, 15, 1, 64'h5555AAAA_5555AAAA);
    chk("lastack_err", cnt_err, 0);
    chk("lastack_req_cycles", cnt_req, 16);
    chk("lastack_data", last_wb, 64'h5555AAAA_5555AAAA);

    // Reset mid-transaction drops the bus request at that edge
    clr_mon();
    valid_i = 1'b1; reg_wr_en_i = 1'b1; mem_rd_en_i = 1'b1; load_code_i = 3'd4;
    addr_mem_rd_i = 64'h7000;
    step();
    idle_in();
    repeat (3) step();
    chk("pre_rst_bus_req", bus_req_o, 1);
    rst = 1'b1;
    step();
    chk("rst_mid_bus_req", bus_req_o, 0);
    chk("rst_mid_hold", hold_req_o, 0);
    rst = 1'b0;
    step();

    valid_i = 1'b1; reg_wr_en_i = 1'b1; addr_reg_wr_i = 5'd31; alu_result_i = 64'hFEED;
    step();
    idle_in();
    chk("post_rst_alu", wb_data_o, 64'hFEED);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
